// File: rtl/fifo_wr_arbiter.sv
// Write-side controller for the async FIFO: round-robin burst arbitration over
// NREQ requesters, binary/Gray write pointers, registered full flag and fill level.
module fifo_wr_arbiter #(
    parameter int ADDRSIZE = 4,
    parameter int DSIZE    = 8,
    parameter int NREQ     = 4
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       last,
    input  logic [NREQ*DSIZE-1:0] din,
    output logic [NREQ-1:0]       ack,
    output logic [NREQ-1:0]       grant,
    input  logic [ADDRSIZE:0]     wq2_rptr,
    output logic [ADDRSIZE:0]     wptr,
    output logic [ADDRSIZE-1:0]   waddr,
    output logic [DSIZE-1:0]      wdata,
    output logic                  wclken,
    output logic                  wfull,
    output logic [ADDRSIZE:0]     wlevel
);

    localparam int OW = $clog2(NREQ);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] BURST = 1'b1;

    logic [0:0]        state;
    logic [OW-1:0]     owner;
    logic [OW-1:0]     rr_ptr;
    logic [ADDRSIZE:0] wbin;
    logic [ADDRSIZE:0] wbinnext;
    logic [ADDRSIZE:0] wgraynext;
    logic [ADDRSIZE:0] rbin_s;
    logic [ADDRSIZE:0] full_cmp;
    logic [OW:0]       sum;
    logic [OW-1:0]     pick;
    logic              pick_valid;
    logic              owner_req;
    logic              owner_last;

    // First requesting index at or after rr_ptr; the descending scan lets the
    // smallest offset overwrite any later candidate.
    always_comb begin
        pick_valid = 1'b0;
        pick       = '0;
        sum        = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr} + (OW+1)'(k);
            if (sum >= (OW+1)'(NREQ)) sum = sum - (OW+1)'(NREQ);
            if (req[sum[OW-1:0]]) begin
                pick_valid = 1'b1;
                pick       = sum[OW-1:0];
            end
        end
    end

    // Handshake: req[i] is valid for din/last of requester i; a word transfers
    // in exactly the cycle ack[i] is high, and ack only ever goes to the owner.
    always_comb begin
        owner_req  = |(req & grant);
        owner_last = |(last & grant);
        wclken     = (state == BURST) & owner_req & ~wfull;
        ack        = wclken ? grant : '0;
        wdata      = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) wdata = din[i*DSIZE +: DSIZE];
        end
    end

    // Binary bit i of a Gray code is the XOR of Gray bits i and above.
    always_comb begin
        rbin_s = '0;
        for (int i = 0; i <= ADDRSIZE; i++) begin
            rbin_s[i] = ^(wq2_rptr >> i);
        end
    end

    assign wbinnext  = wbin + {{ADDRSIZE{1'b0}}, wclken};
    assign wgraynext = (wbinnext >> 1) ^ wbinnext;
    assign full_cmp  = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};
    assign waddr     = wbin[ADDRSIZE-1:0];

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state  <= IDLE;
            grant  <= '0;
            owner  <= '0;
            rr_ptr <= '0;
            wbin   <= '0;
            wptr   <= '0;
            wfull  <= 1'b0;
            wlevel <= '0;
        end else begin
            wbin   <= wbinnext;
            wptr   <= wgraynext;
            wfull  <= (wgraynext == full_cmp);
            wlevel <= wbinnext - rbin_s;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant <= {{(NREQ-1){1'b0}}, 1'b1} << pick;
                        owner <= pick;
                        state <= BURST;
                    end
                end
                BURST: begin
                    // The grant is held through req gaps and wfull stalls until
                    // the word tagged last is actually accepted.
                    if (wclken && owner_last) begin
                        grant  <= '0;
                        rr_ptr <= (owner == OW'(NREQ - 1)) ? '0 : owner + 1'b1;
                        state  <= IDLE;
                    end
                end
                default: begin
                    grant <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized scoreboard bench for fifo_wr_arbiter: burst sources, a delayed
// read-pointer reader, and a round-robin order model feeding an expected queue.
module tb_fifo_wr_arbiter;

    localparam int A = 4;
    localparam int D = 8;
    localparam int N = 4;

    logic           wclk = 1'b0;
    logic           wrst_n;
    logic [N-1:0]   req;
    logic [N-1:0]   last;
    logic [N*D-1:0] din;
    logic [N-1:0]   ack;
    logic [N-1:0]   grant;
    logic [A:0]     wq2_rptr;
    logic [A:0]     wptr;
    logic [A-1:0]   waddr;
    logic [D-1:0]   wdata;
    logic           wclken;
    logic           wfull;
    logic [A:0]     wlevel;

    fifo_wr_arbiter #(.ADDRSIZE(A), .DSIZE(D), .NREQ(N)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .req(req), .last(last), .din(din),
        .ack(ack), .grant(grant), .wq2_rptr(wq2_rptr), .wptr(wptr),
        .waddr(waddr), .wdata(wdata), .wclken(wclken), .wfull(wfull),
        .wlevel(wlevel)
    );

    // ---------------- clock / reset ----------------
    always #5 wclk = ~wclk;

    int checks = 0;
    int errors = 0;

    // expected item: {id[2:0], last, data[7:0], addr[3:0]}
    logic [15:0] exp_q[$];

    // source entry: {gap[3:0], last, data[7:0]}
    logic [12:0] src_mem [N][64];
    int          src_len [N];
    int          src_head[N];
    int          gap_left[N];

    logic       rd_track;
    logic       abort;
    logic [A:0] wp_d1, wp_d2;
    int         wr_seen;
    int         full_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    function automatic logic [4:0] g2b(input logic [4:0] g);
        logic [4:0] b;
        b[4] = g[4];
        for (int i = 3; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    // ---------------- sources / driver tasks ----------------
    task automatic clear_sources();
        for (int i = 0; i < N; i++) begin
            src_len[i]  = 0;
            src_head[i] = 0;
            gap_left[i] = 0;
        end
    endtask

    task automatic add_burst(input int id, input int len, input int gap_pos, input int gap_val);
        for (int k = 0; k < len; k++) begin
            src_mem[id][src_len[id]] = {(k == gap_pos) ? 4'(gap_val) : 4'd0,
                                        (k == len - 1), 8'($urandom_range(0, 255))};
            src_len[id]++;
        end
    endtask

    function automatic bit pending();
        bit p = 1'b0;
        for (int i = 0; i < N; i++) if (src_head[i] < src_len[i]) p = 1'b1;
        return p;
    endfunction

    // Round-robin order over whole bursts: every requester with work left is
    // requesting at each arbitration, so the grant sequence follows directly.
    task automatic build_model();
        int hd[N];
        int rr = 0;
        int wc = 0;
        int found;
        logic [12:0] e;
        for (int i = 0; i < N; i++) hd[i] = 0;
        forever begin
            found = -1;
            for (int k = 0; k < N; k++) begin
                if (found < 0 && hd[(rr + k) % N] < src_len[(rr + k) % N]) found = (rr + k) % N;
            end
            if (found < 0) break;
            do begin
                e = src_mem[found][hd[found]];
                exp_q.push_back({3'(found), e[8], e[7:0], 4'(wc)});
                wc++;
                hd[found]++;
            end while (!e[8]);
            rr = (found + 1) % N;
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            if (src_head[i] < src_len[i] && gap_left[i] == 0) begin
                req[i]       = 1'b1;
                last[i]      = src_mem[i][src_head[i]][8];
                din[i*D +: D] = src_mem[i][src_head[i]][7:0];
            end else begin
                req[i]       = 1'b0;
                last[i]      = 1'($urandom_range(0, 1));
                din[i*D +: D] = 8'($urandom_range(0, 255));
            end
        end
    endtask

    task automatic advance(input logic [N-1:0] acc);
        for (int i = 0; i < N; i++) if (gap_left[i] > 0) gap_left[i]--;
        for (int i = 0; i < N; i++) begin
            if (acc[i] && src_head[i] < src_len[i]) begin
                src_head[i]++;
                if (src_head[i] < src_len[i]) gap_left[i] = int'(src_mem[i][src_head[i]][12:9]);
            end
        end
    endtask

    task automatic run_traffic(input int max_cycles);
        int cyc = 0;
        logic [N-1:0] acc;
        drive_inputs();
        while (!abort && (pending() || exp_q.size() != 0)) begin
            if (cyc >= max_cycles) begin
                fail_now("traffic_timeout");
                break;
            end
            @(negedge wclk);
            acc = ack;
            @(posedge wclk);
            #1;
            if (abort) break;
            advance(acc);
            drive_inputs();
            cyc++;
        end
    endtask

    task automatic do_reset();
        wrst_n   = 1'b0;
        rd_track = 1'b0;
        abort    = 1'b0;
        wq2_rptr = '0;
        wp_d1    = '0;
        wp_d2    = '0;
        clear_sources();
        drive_inputs();
        repeat (2) @(negedge wclk);
    endtask

    task automatic release_reset();
        @(posedge wclk);
        #1;
        wrst_n = 1'b1;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_grant"}, grant, 0);
        check({tag, "_ack"}, ack, 0);
        check({tag, "_wclken"}, wclken, 0);
        check({tag, "_wptr"}, wptr, 0);
        check({tag, "_wfull"}, wfull, 0);
        check({tag, "_wlevel"}, wlevel, 0);
    endtask

    task automatic check_first_grant(input logic [N-1:0] exp_grant);
        @(negedge wclk);
        check("arb_latency_grant", grant, 0);
        check("arb_latency_wclken", wclken, 0);
        @(negedge wclk);
        check("first_grant", grant, exp_grant);
    endtask

    // ---------------- read pointer model ----------------
    initial begin
        forever begin
            @(posedge wclk);
            #1;
            if (rd_track) wq2_rptr = wp_d2;
            wp_d2 = wp_d1;
            wp_d1 = wptr;
        end
    end

    // ---------------- scoreboard monitor ----------------
    logic        mid_burst, prev_last;
    logic [2:0]  cur_id;
    logic [4:0]  prev_rq, n_w, exp_lvl;
    logic [15:0] item;

    initial begin
        forever begin
            @(negedge wclk);
            if (!wrst_n) begin
                exp_q.delete();
                wr_seen   = 0;
                mid_burst = 1'b0;
                prev_last = 1'b0;
                prev_rq   = wq2_rptr;
            end else begin
                n_w     = wr_seen[4:0];
                exp_lvl = n_w - g2b(prev_rq);
                check("wptr_gray", wptr, n_w ^ (n_w >> 1));
                check("wlevel", wlevel, exp_lvl);
                check("wfull", wfull, exp_lvl == 5'd16);
                if (wfull) full_cnt++;
                if (!wclken) check("ack_idle", ack, 0);
                if (prev_last) begin
                    check("idle_bubble", wclken, 0);
                    check("grant_clear", grant, 0);
                end else if (mid_burst) begin
                    check("grant_hold", grant, 32'(1) << cur_id);
                end
                prev_last = 1'b0;
                if (wclken) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_write");
                    end else begin
                        item = exp_q.pop_front();
                        check("ack_owner", ack, 32'(1) << item[15:13]);
                        check("grant_owner", grant, 32'(1) << item[15:13]);
                        check("wdata", wdata, item[11:4]);
                        check("waddr", waddr, item[3:0]);
                        mid_burst = ~item[12];
                        prev_last = item[12];
                        cur_id    = item[15:13];
                    end
                    wr_seen++;
                end
                prev_rq = wq2_rptr;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- scenarios ----------------
    initial begin
        req      = '0;
        last     = '0;
        din      = '0;
        full_cnt = 0;
        wr_seen  = 0;

        // Random bursts from all requesters, req high through reset.
        for (int round = 0; round < 2; round++) begin
            do_reset();
            for (int i = 0; i < N; i++) begin
                for (int b = 0; b < 3; b++) begin
                    int len = $urandom_range(1, 4);
                    if (len > 1 && $urandom_range(0, 1) == 1)
                        add_burst(i, len, $urandom_range(1, len - 1), $urandom_range(1, 5));
                    else
                        add_burst(i, len, -1, 0);
                end
            end
            build_model();
            drive_inputs();
            if (round == 0) check_zero_outputs("reset_state");
            release_reset();
            rd_track = 1'b1;
            fork
                run_traffic(400);
                check_first_grant(4'b0001);
            join
        end

        // Requesters 0 and 2, two 3-word bursts each.
        do_reset();
        add_burst(0, 3, -1, 0); add_burst(0, 3, -1, 0);
        add_burst(2, 3, -1, 0); add_burst(2, 3, -1, 0);
        build_model();
        drive_inputs();
        release_reset();
        rd_track = 1'b1;
        run_traffic(200);

        // Requester 1 fills the FIFO with the read pointer frozen at 0.
        do_reset();
        add_burst(1, 20, -1, 0);
        build_model();
        drive_inputs();
        release_reset();
        fork
            run_traffic(400);
            begin
                int cyc = 0;
                while (!wfull && cyc < 100) begin @(negedge wclk); cyc++; end
                if (!wfull) begin
                    fail_now("full_timeout");
                end else begin
                    check("full_level", wlevel, 16);
                    check("full_wptr", wptr, 5'b11000);
                    check("full_no_write", wclken, 0);
                    repeat (3) begin
                        @(negedge wclk);
                        check("full_stall", wclken, 0);
                    end
                    @(posedge wclk); #1;
                    wq2_rptr = 5'b00001;
                    @(negedge wclk);
                    check("full_pessimistic", wfull, 1);
                    @(negedge wclk);
                    check("full_release", wfull, 0);
                    check("write_resumes", wclken, 1);
                    @(negedge wclk);
                    check("refull", wfull, 1);
                    check("refull_level", wlevel, 16);
                end
                rd_track = 1'b1;
            end
        join

        // 40 single-word bursts across the pointer wrap.
        do_reset();
        for (int b = 0; b < 10; b++) for (int i = 0; i < N; i++) add_burst(i, 1, -1, 0);
        build_model();
        drive_inputs();
        full_cnt = 0;
        release_reset();
        rd_track = 1'b1;
        run_traffic(400);
        check("wrap_never_full", full_cnt, 0);
        check("wrap_write_count", wr_seen, 40);

        // Owner pauses 5 cycles mid-burst while requester 3 waits.
        do_reset();
        add_burst(0, 6, 2, 5);
        add_burst(3, 2, -1, 0);
        add_burst(3, 3, -1, 0);
        build_model();
        drive_inputs();
        release_reset();
        rd_track = 1'b1;
        run_traffic(200);

        // Reset asserted mid-burst at wbin = 7, then arbitration restarts at 0.
        do_reset();
        add_burst(2, 12, -1, 0);
        add_burst(1, 2, -1, 0);
        build_model();
        drive_inputs();
        release_reset();
        rd_track = 1'b1;
        fork
            run_traffic(300);
            begin
                int cyc = 0;
                while (wptr !== 5'b00100 && cyc < 100) begin @(negedge wclk); cyc++; end
                if (wptr !== 5'b00100) fail_now("wbin7_timeout");
                #2;
                wrst_n   = 1'b0;
                abort    = 1'b1;
                rd_track = 1'b0;
                #1;
                check_zero_outputs("async_reset");
            end
        join
        do_reset();
        add_burst(3, 2, -1, 0);
        add_burst(1, 2, -1, 0);
        add_burst(0, 3, -1, 0);
        build_model();
        drive_inputs();
        release_reset();
        rd_track = 1'b1;
        fork
            run_traffic(200);
            check_first_grant(4'b0001);
        join

        repeat (2) @(negedge wclk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Write-side controller for the async FIFO. Shares the single FIFO write port among NREQ requesters using round-robin arbitration, with the grant locked for a whole burst.
- Owns the binary and Gray write pointers and drives the FIFO memory write strobe and address.
- Generates wfull and a fill level from the read pointer after it has been synchronized into wclk.
- Sits entirely in the wclk domain, between the requesters and the FIFO memory / pointer synchronizers.

Parameters:
- ADDRSIZE, 4, FIFO address width; depth = 2**ADDRSIZE.
- DSIZE, 8, data word width.
- NREQ, 4, number of requesters (2..8).

Ports:
- wclk  input  1  write-domain clock.
- wrst_n  input  1  asynchronous active-low reset.
- req  input  NREQ  per-requester word valid.
- last  input  NREQ  per-requester end-of-burst marker, qualified by req.
- din  input  NREQ*DSIZE  flattened requester data; requester i occupies bits [i*DSIZE +: DSIZE].
- ack  output  NREQ  one-hot; word accepted from requester i this cycle.
- grant  output  NREQ  one-hot registered burst owner; all zeros when idle.
- wq2_rptr  input  ADDRSIZE+1  Gray read pointer, already synchronized into wclk.
- wptr  output  ADDRSIZE+1  registered Gray write pointer, sent to the read-domain synchronizer.
- waddr  output  ADDRSIZE  memory write address = wbin[ADDRSIZE-1:0].
- wdata  output  DSIZE  memory write data, muxed from the owner.
- wclken  output  1  memory write enable.
- wfull  output  1  registered full flag.
- wlevel  output  ADDRSIZE+1  registered occupancy as seen from wclk (0..2**ADDRSIZE).

Behaviour:
- Reset (async, wrst_n low) forces:
  - wbin = 0, wptr = 0, wfull = 0, wlevel = 0, grant = 0.
  - State = IDLE; round-robin pointer set so requester 0 has top priority.
  - Combinational outputs ack = 0 and wclken = 0.
- Reset asserted mid-burst discards the burst. No partial-pointer recovery.
- State machine:
  - IDLE: if any req is set, select the first requester at or after rr_ptr (wrapping); register its one-hot grant; go to BURST. No word is written in the IDLE cycle (1-cycle arbitration latency).
  - BURST: wclken = req[owner] & ~wfull. When wclken is high, ack[owner] = 1, wdata = din[owner], and the word is written at waddr.
  - If the accepted word has last[owner] = 1: grant clears, rr_ptr = owner+1 mod NREQ, state goes to IDLE.
  - If req[owner] drops with no last, the owner keeps the grant; no other requester is served.
  - Requests from non-owners are ignored during BURST and never get ack.
- Pointer update on every wclken:
  - wbinnext = wbin + 1, wrapping modulo 2**(ADDRSIZE+1).
  - wgraynext = (wbinnext>>1) ^ wbinnext.
  - wptr is registered from wgraynext.
- Full flag:
  - wfull <= (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}), with wgraynext = current Gray pointer when no write occurs.
  - wfull is pessimistic: it deasserts only after a read pointer advance reaches wq2_rptr.
  - A write is never issued while wfull = 1.
- Level:
  - rbin_s = Gray-to-binary of wq2_rptr.
  - wlevel <= wbinnext - rbin_s, computed modulo 2**(ADDRSIZE+1). Equals 2**ADDRSIZE when full.
- Simultaneous events:
  - A last word accepted while the FIFO becomes full is legal; the controller returns to IDLE normally.
  - A last word held off by wfull keeps the grant until it is accepted.
- Wrap-around: the MSB of wbin toggles every 2**ADDRSIZE writes; full/empty detection relies on this.

Test Plan:
- Reset with all req set, then release wrst_n: grant = 0001 one cycle later, first ack[0] on the next cycle, wptr = 0 and wlevel = 0 beforehand.
- Requesters 0 and 2 each send 3-word bursts, both req held: order is R0 ×3, one IDLE bubble, R2 ×3, then R0. ack is one-hot and never asserts for a non-owner.
- Requester 1 streams 16 words with wq2_rptr held at 0: wfull = 1 after the 16th write, wlevel = 16, wptr = 5'b11000, wclken = 0 while req stays high. Set wq2_rptr = 5'b00001: two cycles later wfull = 0 and the write resumes.
- 40 single-word bursts with wq2_rptr tracking wptr delayed 2 cycles: waddr wraps 15→0, wptr follows the Gray sequence across the MSB toggle, and wfull is never set.
- Owner drops req for 5 cycles mid-burst with no last while requester 3 requests: grant stays on the owner, ack[3] = 0 throughout, and the owner's burst resumes.
- Assert wrst_n low mid-burst at wbin = 7: all outputs return to their reset values asynchronously. After release, arbitration restarts at requester 0.
